// File: rtl/video_timing_gen_pkg.sv
// Shared definitions for the video timing generator: pattern-select encoding
// and the colour-bar palette.
package video_timing_gen_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_BOX     = 2'd3
  } pat_e;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_TABLE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [23:0] grey(input logic [7:0] lvl);
    return {lvl, lvl, lvl};
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Registered video output bundle: data enable, syncs, RGB pixel and frame marker.
interface video_timing_gen_if;

  logic        de_out;
  logic        h_sync_out;
  logic        v_sync_out;
  logic [23:0] pixel_out;
  logic        frame_start;

  modport master (
    output de_out,
    output h_sync_out,
    output v_sync_out,
    output pixel_out,
    output frame_start
  );

  modport slave (
    input de_out,
    input h_sync_out,
    input v_sync_out,
    input pixel_out,
    input frame_start
  );

endinterface

// File: rtl/video_pattern_rom.sv
// Combinational test-pattern generator: maps pattern select, raster position
// and box origin to a 24-bit RGB value.
module video_pattern_rom
  import video_timing_gen_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int BOX   = 8
) (
  input  pat_e               pat,
  input  logic [CNT_W-1:0]   hc,
  input  logic [CNT_W-1:0]   vc,
  input  logic [CNT_W-1:0]   bx,
  input  logic [CNT_W-1:0]   by,
  output logic [23:0]        rgb
);

  logic [31:0] bar_wide;
  logic [31:0] ramp_wide;
  logic [2:0]  bar_idx;
  logic [7:0]  ramp;
  logic        in_box;

  // Constant divisors reduce to shifts when IMG_W is a power of two.
  always_comb begin
    bar_wide  = {17'd0, hc, 3'd0} / IMG_W;
    bar_idx   = (bar_wide > 32'd7) ? 3'd7 : bar_wide[2:0];
    ramp_wide = {16'd0, hc[7:0], 8'd0} / IMG_W;
    ramp      = (ramp_wide > 32'd255) ? 8'hFF : ramp_wide[7:0];
    in_box    = (hc >= bx) && (32'(hc) < 32'(bx) + BOX) &&
                (vc >= by) && (32'(vc) < 32'(by) + BOX);

    rgb = 24'h000000;
    case (pat)
      PAT_BARS:    rgb = BAR_TABLE[bar_idx];
      PAT_RAMP:    rgb = grey(ramp);
      PAT_CHECKER: rgb = (hc[3] ^ vc[3]) ? 24'hFFFFFF : 24'h000000;
      PAT_BOX:     rgb = in_box ? 24'hFFFFFF : 24'h000000;
      default:     rgb = 24'h000000;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with selectable test patterns; counters live here,
// pixel colour comes from video_pattern_rom.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int H_FP   = 4,
  parameter int H_SYNC = 4,
  parameter int H_BP   = 8,
  parameter int V_FP   = 2,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 4,
  parameter int BOX    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [1:0]         pat,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = IMG_W + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = IMG_H + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] hc, vc, bx, by;
  pat_e             pat_q;
  pat_e             pat_eff;
  logic             h_end, v_end, frame_origin;
  logic             active, hs_region, vs_region;
  logic [23:0]      rgb;

  always_comb begin
    h_end        = (hc == CNT_W'(H_TOTAL - 1));
    v_end        = (vc == CNT_W'(V_TOTAL - 1));
    frame_origin = (hc == '0) && (vc == '0);
    active       = (hc < CNT_W'(IMG_W)) && (vc < CNT_W'(IMG_H));
    hs_region    = (hc >= CNT_W'(IMG_W + H_FP)) &&
                   (hc <  CNT_W'(IMG_W + H_FP + H_SYNC));
    vs_region    = (vc >= CNT_W'(IMG_H + V_FP)) &&
                   (vc <  CNT_W'(IMG_H + V_FP + V_SYNC));
    // The first pixel of a frame already uses the newly sampled pattern.
    pat_eff      = frame_origin ? pat_e'(pat) : pat_q;
  end

  video_pattern_rom #(
    .IMG_W (IMG_W),
    .BOX   (BOX)
  ) u_rom (
    .pat (pat_eff),
    .hc  (hc),
    .vc  (vc),
    .bx  (bx),
    .by  (by),
    .rgb (rgb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc <= '0;
      vc <= '0;
    end else if (ce) begin
      if (h_end) begin
        hc <= '0;
        vc <= v_end ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Box advances once per frame, stepping down a row after each horizontal sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bx <= '0;
      by <= '0;
    end else if (ce && h_end && v_end) begin
      if (bx == CNT_W'(IMG_W - BOX - 1)) begin
        bx <= '0;
        by <= (by == CNT_W'(IMG_H - BOX - 1)) ? '0 : by + 1'b1;
      end else begin
        bx <= bx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= PAT_BARS;
    end else if (ce && frame_origin) begin
      pat_q <= pat_e'(pat);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vid.de_out      <= 1'b0;
      vid.h_sync_out  <= 1'b0;
      vid.v_sync_out  <= 1'b0;
      vid.pixel_out   <= 24'h000000;
      vid.frame_start <= 1'b0;
    end else if (ce) begin
      vid.de_out      <= active;
      vid.h_sync_out  <= hs_region;
      vid.v_sync_out  <= vs_region;
      vid.pixel_out   <= active ? rgb : 24'h000000;
      vid.frame_start <= frame_origin;
    end else begin
      vid.frame_start <= 1'b0;
    end
  end

endmodule
